// File: rtl/winograd_tile_feeder_pkg.sv
// Shared types and helpers for the Winograd tile feeder: state encoding, widths, buffer rotation.
package winograd_tile_feeder_pkg;

  localparam int PIX_W = 8;
  localparam int CNT_W = 20;
  localparam int NUM_LB = 6;

  typedef enum logic [1:0] {
    INIT_STATE = 2'd0,
    STATE1     = 2'd1,
    STATE2     = 2'd2,
    STATE3     = 2'd3
  } state_e;

  function automatic state_e next_strip_state(state_e s);
    case (s)
      STATE1:  return STATE2;
      STATE2:  return STATE3;
      default: return STATE1;
    endcase
  endfunction

  // Buffer index (0-based, modulo the ring of six) offset from a base buffer.
  function automatic logic [2:0] lb_index(logic [2:0] base, int off);
    int v;
    v = int'(base) + off;
    return 3'(v % NUM_LB);
  endfunction

  // Buffer holding the top tile row in a given strip state; the fill set follows four later.
  function automatic logic [2:0] read_base(state_e s);
    case (s)
      STATE2:  return 3'd2;
      STATE3:  return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/winograd_tile_feeder_if.sv
// Pixel stream in, tile + ready out, proc_finish ack from the consumer.
interface winograd_tile_feeder_if #(
  parameter int M = 3,
  parameter int N = 4
);
  logic [7:0]           i_pixel_data;
  logic                 i_pixel_data_valid;
  logic                 proc_finish;
  logic [M*N*N*8-1:0]   o_input_tile_across_all_channel;
  logic                 o_ready;

  modport master (
    output i_pixel_data, i_pixel_data_valid, proc_finish,
    input  o_input_tile_across_all_channel, o_ready
  );

  modport slave (
    input  i_pixel_data, i_pixel_data_valid, proc_finish,
    output o_input_tile_across_all_channel, o_ready
  );
endinterface

// File: rtl/winograd_tile_feeder_line_buffer.sv
// One image row (M*W bytes) with a wrapping write pointer; combinational N*M-byte window read.
// Window bytes past the end of the row read as zero.
module winograd_tile_feeder_line_buffer
  import winograd_tile_feeder_pkg::*;
#(
  parameter int M = 3,
  parameter int W = 10,
  parameter int N = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIX_W-1:0]       data,
  input  logic                   valid,
  input  logic [CNT_W-1:0]       rd_base,
  output logic [N*M*PIX_W-1:0]   rd_dat
);
  localparam int LINE = M * W;
  localparam int PW   = $clog2(LINE);

  logic [PIX_W-1:0] line [0:LINE-1];
  logic [PW-1:0]    wr_pntr_q, wr_pntr_d;
  logic [CNT_W-1:0] addr;

  always_comb begin
    wr_pntr_d = wr_pntr_q;
    if (valid) begin
      wr_pntr_d = (wr_pntr_q == PW'(LINE - 1)) ? '0 : wr_pntr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wr_pntr_q <= '0;
    else     wr_pntr_q <= wr_pntr_d;
  end

  // Contents survive reset; only the pointer restarts.
  always_ff @(posedge clk) begin
    if (!rst && valid) line[wr_pntr_q] <= data;
  end

  always_comb begin
    rd_dat = '0;
    addr   = '0;
    for (int i = 0; i < N * M; i++) begin
      addr = rd_base + CNT_W'(i);
      if (addr < CNT_W'(LINE)) rd_dat[i*PIX_W +: PIX_W] = line[addr[PW-1:0]];
    end
  end

endmodule

// File: rtl/winograd_tile_feeder.sv
// Six rotating line buffers feeding stride-2 NxN tiles for all channels; tile valid one cycle after
// proc_finish, extra pixels are dropped while the two-row fill set is full.
module winograd_tile_feeder
  import winograd_tile_feeder_pkg::*;
#(
  parameter int M = 3,
  parameter int W = 10,
  parameter int N = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  winograd_tile_feeder_if.slave bus
);
  localparam int LINE = M * W;
  localparam int T    = (W - N) / 2 + 1;
  localparam int LBW  = N * M * PIX_W;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             ready_q, ready_d;

  logic             wr_en;
  logic [2:0]       wr_sel;
  logic [5:0]       lb_vld;
  logic [CNT_W-1:0] rd_base;
  logic [LBW-1:0]   lb_rd [NUM_LB];
  logic [2:0]       row_sel;
  logic [M*N*N*PIX_W-1:0] tile;

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    wr_en      = 1'b0;
    wr_sel     = '0;
    case (state_q)
      INIT_STATE: begin
        if (fill_cnt_q == CNT_W'(4 * LINE)) begin
          state_d    = STATE1;
          fill_cnt_d = '0;
          rd_cnt_d   = '0;
        end else if (bus.i_pixel_data_valid) begin
          wr_en      = 1'b1;
          wr_sel     = (fill_cnt_q < CNT_W'(LINE))     ? 3'd0 :
                       (fill_cnt_q < CNT_W'(2 * LINE)) ? 3'd1 :
                       (fill_cnt_q < CNT_W'(3 * LINE)) ? 3'd2 : 3'd3;
          fill_cnt_d = fill_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (rd_cnt_q == CNT_W'(T) && fill_cnt_q == CNT_W'(2 * LINE)) begin
          state_d    = next_strip_state(state_q);
          fill_cnt_d = '0;
          rd_cnt_d   = '0;
        end else begin
          if (bus.i_pixel_data_valid && fill_cnt_q < CNT_W'(2 * LINE)) begin
            wr_en      = 1'b1;
            wr_sel     = lb_index(read_base(state_q), (fill_cnt_q >= CNT_W'(LINE)) ? 5 : 4);
            fill_cnt_d = fill_cnt_q + CNT_W'(1);
          end
          if (ready_q && bus.proc_finish) rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
      end
    endcase
    ready_d = (state_d != INIT_STATE) && (rd_cnt_d < CNT_W'(T));
    lb_vld  = '0;
    if (wr_en) lb_vld[wr_sel] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= INIT_STATE;
      fill_cnt_q <= '0;
      rd_cnt_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      ready_q    <= ready_d;
    end
  end

  // Tile t starts at column 2t, i.e. byte 2t*M of every row.
  assign rd_base = rd_cnt_q * CNT_W'(2 * M);

  winograd_tile_feeder_line_buffer #(.M(M), .W(W), .N(N)) lb1 (.clk(i_clk), .rst(i_rst),
    .data(bus.i_pixel_data), .valid(lb_vld[0]), .rd_base(rd_base), .rd_dat(lb_rd[0]));
  winograd_tile_feeder_line_buffer #(.M(M), .W(W), .N(N)) lb2 (.clk(i_clk), .rst(i_rst),
    .data(bus.i_pixel_data), .valid(lb_vld[1]), .rd_base(rd_base), .rd_dat(lb_rd[1]));
  winograd_tile_feeder_line_buffer #(.M(M), .W(W), .N(N)) lb3 (.clk(i_clk), .rst(i_rst),
    .data(bus.i_pixel_data), .valid(lb_vld[2]), .rd_base(rd_base), .rd_dat(lb_rd[2]));
  winograd_tile_feeder_line_buffer #(.M(M), .W(W), .N(N)) lb4 (.clk(i_clk), .rst(i_rst),
    .data(bus.i_pixel_data), .valid(lb_vld[3]), .rd_base(rd_base), .rd_dat(lb_rd[3]));
  winograd_tile_feeder_line_buffer #(.M(M), .W(W), .N(N)) lb5 (.clk(i_clk), .rst(i_rst),
    .data(bus.i_pixel_data), .valid(lb_vld[4]), .rd_base(rd_base), .rd_dat(lb_rd[4]));
  winograd_tile_feeder_line_buffer #(.M(M), .W(W), .N(N)) lb6 (.clk(i_clk), .rst(i_rst),
    .data(bus.i_pixel_data), .valid(lb_vld[5]), .rd_base(rd_base), .rd_dat(lb_rd[5]));

  // Reorder each row window (col-major, channel-minor) into tile[ch][row][col].
  always_comb begin
    tile    = '0;
    row_sel = '0;
    for (int row = 0; row < N; row++) begin
      row_sel = lb_index(read_base(state_q), row);
      for (int ch = 0; ch < M; ch++) begin
        for (int col = 0; col < N; col++) begin
          tile[((ch*N + row)*N + col)*PIX_W +: PIX_W] = lb_rd[row_sel][(col*M + ch)*PIX_W +: PIX_W];
        end
      end
    end
  end

  assign bus.o_input_tile_across_all_channel = tile;
  assign bus.o_ready                         = ready_q;

endmodule

// File: tb/tb_winograd_tile_feeder.sv
// Random pixel/ack stimulus checked every cycle against an image-row reference model.
module tb_winograd_tile_feeder;
  import winograd_tile_feeder_pkg::*;

  localparam int M  = 3;
  localparam int W  = 10;
  localparam int N  = 4;
  localparam int L  = M * W;
  localparam int T  = (W - N) / 2 + 1;
  localparam int TW = M * N * N * 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  winograd_tile_feeder_if #(.M(M), .N(N)) bus ();
  winograd_tile_feeder #(.M(M), .W(W), .N(N)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: accepted pixels form a flat image; strip s covers image rows 2s..2s+3.
  bit         m_started;
  int         m_s, m_t, m_acc;
  logic [7:0] img [0:4095];

  function automatic bit m_ready();
    return m_started && (m_t < T);
  endfunction

  function automatic int m_state();
    return m_started ? 1 + (m_s % 3) : 0;
  endfunction

  function automatic logic [TW-1:0] m_tile();
    logic [TW-1:0] v;
    v = '0;
    for (int ch = 0; ch < M; ch++)
      for (int row = 0; row < N; row++)
        for (int col = 0; col < N; col++)
          v[((ch*N + row)*N + col)*8 +: 8] = img[(2*m_s + row)*L + (2*m_t + col)*M + ch];
    return v;
  endfunction

  task automatic model_step(input logic vld, input logic [7:0] d, input logic pf, input logic r);
    int  limit;
    bit  rdy;
    rdy = m_ready();
    if (r) begin
      m_started = 0; m_s = 0; m_t = 0; m_acc = 0;
    end else if (!m_started) begin
      if (m_acc == 4 * L) begin
        m_started = 1; m_t = 0;
      end else if (vld) begin
        img[m_acc] = d; m_acc++;
      end
    end else begin
      limit = L * (6 + 2 * m_s);
      if (m_t == T && m_acc == limit) begin
        m_s++; m_t = 0;
      end else begin
        if (vld && m_acc < limit) begin
          img[m_acc] = d; m_acc++;
        end
        if (rdy && pf) m_t++;
      end
    end
  endtask

  task automatic tick(input logic vld, input logic [7:0] d, input logic pf, input logic r);
    bus.i_pixel_data_valid = vld;
    bus.i_pixel_data       = d;
    bus.proc_finish        = pf;
    rst                    = r;
    @(posedge clk);
    model_step(vld, d, pf, r);
    @(negedge clk);
    check("ready", TW'(bus.o_ready), TW'(m_ready()));
    check("state", TW'(dut.state_q), TW'(m_state()));
    if (m_ready()) check("tile", bus.o_input_tile_across_all_channel, m_tile());
  endtask

  task automatic check_wr_pntrs(input string tag, input bit all6);
    check({tag, "_lb1"}, TW'(dut.lb1.wr_pntr_q), '0);
    check({tag, "_lb2"}, TW'(dut.lb2.wr_pntr_q), '0);
    check({tag, "_lb3"}, TW'(dut.lb3.wr_pntr_q), '0);
    check({tag, "_lb4"}, TW'(dut.lb4.wr_pntr_q), '0);
    if (all6) begin
      check({tag, "_lb5"}, TW'(dut.lb5.wr_pntr_q), '0);
      check({tag, "_lb6"}, TW'(dut.lb6.wr_pntr_q), '0);
    end
  endtask

  task automatic random_ticks(input int n);
    for (int i = 0; i < n; i++)
      tick(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) == 0), 1'b0);
  endtask

  logic [TW-1:0] snap;
  int            guard;

  initial begin
    m_started = 0; m_s = 0; m_t = 0; m_acc = 0;
    bus.i_pixel_data = '0; bus.i_pixel_data_valid = 1'b0; bus.proc_finish = 1'b0; rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0, 1'b1);
    check_wr_pntrs("rst_wrpntr", 1'b1);

    // Counting pattern: every row holds its own byte index.
    for (int i = 0; i < 4 * L; i++) tick(1'b1, 8'(i % L), 1'b0, 1'b0);
    check_wr_pntrs("init_wrap", 1'b0);
    check("init_ready_early", TW'(bus.o_ready), '0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    check("init_ready", TW'(bus.o_ready), TW'(1));
    snap = bus.o_input_tile_across_all_channel;
    check("tile0_b2_3_3", TW'(snap[((2*N + 3)*N + 3)*8 +: 8]), TW'(11));
    check("tile0_b0_1_2", TW'(snap[((0*N + 1)*N + 2)*8 +: 8]), TW'(6));

    // Overfill the strip's fill set with no acks; only two rows may land.
    for (int i = 0; i < 3 * L; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0);
    check("ovf_accepted", TW'(m_acc), TW'(6 * L));

    for (int k = 0; k < T; k++) begin
      tick(1'b0, 8'h00, 1'b1, 1'b0);
      tick(1'b0, 8'h00, 1'b0, 1'b0);
    end
    check("strip2_state", TW'(dut.state_q), TW'(STATE2));

    random_ticks(1500);

    guard = 0;
    while (m_state() != 2 && guard < 3000) begin
      random_ticks(1);
      guard++;
    end
    check("reach_state2", TW'(m_state()), TW'(2));
    random_ticks(7);
    tick(1'b1, 8'($urandom), 1'b1, 1'b1);
    check_wr_pntrs("midrst_wrpntr", 1'b1);
    check("midrst_fill_cnt", TW'(dut.fill_cnt_q), '0);
    check("midrst_rd_cnt", TW'(dut.rd_cnt_q), '0);

    random_ticks(900);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
